imem_arbiter: RTL
=================

// Module: imem_arbiter
// PURPOSE
//  Shares the single byte-serial instruction memory (16 beats per 128-bit block) between two i-cache
//  requesters: port 0 = active i-cache, port 1 = standby i-cache being warmed for a context switch.
//  Grants one requester at a time, holds the block address for the full burst and returns the
//  registered block with a one-cycle acknowledge. Sits between both i-caches and Instruction_memory.
// PARAMETERS
//  ADDR_W  28   block address width (byte address >> 4)
//  DATA_W  128  block width
//  BEATS   16   memory beats per block; beat counter width = $clog2(BEATS)
// PORTS
//  clock          in   1       system clock
//  reset          in   1       asynchronous reset, active-low (0 = reset)
//  req_read       in   2       per-port read request; held high until ack
//  req_address    in   2xADDR_W per-port block address; stable while req_read high
//  req_readdata   out  DATA_W  returned block, shared by both ports; valid when owner's busywait drops
//  req_busywait   out  2       per-port stall: req_read[i] && !ack[i] (combinational)
//  mem_read       out  1       to memory read
//  mem_address    out  ADDR_W  to memory address, latched at grant
//  mem_readdata   in   DATA_W  from memory readdata
//  mem_busywait   in   1       from memory busywait
//  grant          out  2       one-hot current owner, 0 when idle
// BEHAVIOUR
//  - States: IDLE -> BUSY -> CAPTURE -> ACK -> IDLE.
//  - IDLE: mem_read=0. If any req_read: pick owner, latch its address into mem_address, beat=0, -> BUSY.
//  - BUSY: mem_read=1 for exactly BEATS cycles; beat increments each cycle; at beat==BEATS-1 -> CAPTURE.
//    mem_busywait must be 0 in the last BUSY cycle; mismatch is a protocol error (assertion only).
//  - CAPTURE: mem_read=0 (memory beat counter has wrapped to 0); latch mem_readdata into req_readdata.
//  - ACK: ack[owner]=1 for one cycle, so req_busywait[owner]=0; -> IDLE, grant cleared.
//  - Latency: req_read at cycle 0 (idle) -> busywait low in cycle 18; back-to-back grant every 19 cycles.
//  - mem_read must never be high outside BUSY: memory beat alignment depends on exact 16-cycle bursts.
//  - Requester drops req_read mid-burst: burst completes (no abort), data captured, no ack.
//  - Requester address change mid-burst: ignored; latched address used.
//  - Reset: state=IDLE, beat=0, mem_read=0, mem_address=0, req_readdata=0, grant=0, last_owner=1.
//    Reset mid-burst aborts; memory shares the reset (top drives memory reset = ~reset) so its
//    counter realigns. Requester busywaits follow req_read during reset.
// CONFIGURATION
//  IMEM_ARB_RR_EN defined: round-robin; on simultaneous requests the port != last_owner wins;
//    last_owner updates at ACK.
//  Undefined: fixed priority, port 0 always wins (port 1 can starve; intentional for active cache).
// STRUCTURE
//  Package imem_arb_pkg: state encoding (IDLE/BUSY/CAPTURE/ACK), BEATS, BEAT_W, port index constants.
//  Sub-module imem_arb_pick: combinational picker (req_read, last_owner) -> one-hot pick;
//  contains the IMEM_ARB_RR_EN ifdef.
// TESTING (bench uses Instruction_memory with its default contents)
//  1 port0 read addr 0 alone -> mem_read high 16 cycles, busywait[0] low cycle 18,
//    readdata[31:0]=32'hc1800013, [63:32]=32'h00208093.
//  2 port1 read addr 1 alone -> readdata[31:0]=32'h0000a2a3, grant=2'b10 during burst.
//  3 both read same cycle (p0 addr 0, p1 addr 2), p0 drops after ack -> p0 acked cycle 18,
//    p1 acked cycle 37 with readdata[31:0]=32'h0050a103.
//  4 IMEM_ARB_RR_EN, both hold req_read continuously -> acks alternate p0,p1,p0;
//    without macro -> p0 only, p1 busywait stays high.
//  5 p0 drops req_read at beat 5 -> burst runs to 16 beats, no ack, IDLE next; following p1 read correct.
//  6 reset asserted at beat 7 -> mem_read=0, grant=0 immediately; after release, port0 addr 2 read
//    returns 32'h0050a103.

Source files
------------

// File: rtl/imem_arb_pkg.sv
// imem_arb_pkg: shared constants, state encoding and small helpers for the
// instruction-memory arbiter (imem_arbiter, imem_arb_pick, imem_arb_checker).
package imem_arb_pkg;

    // Memory beats per 128-bit block and the matching beat-counter width
    localparam int DEF_BEATS  = 16;
    localparam int DEF_BEAT_W = $clog2(DEF_BEATS);

    // Requester ports: 0 = active i-cache, 1 = standby i-cache being warmed
    localparam int N_PORTS      = 2;
    localparam int PORT_ACTIVE  = 0;
    localparam int PORT_STANDBY = 1;

    // Arbiter sequencing: grant -> 16-beat burst -> capture block -> acknowledge
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_ACK     = 2'd3
    } arb_state_e;

    // Port index of the owner encoded in a one-hot two-port grant vector
    function automatic logic grant_index(input logic [N_PORTS-1:0] oh);
        return oh[PORT_STANDBY];
    endfunction

endpackage

// File: rtl/imem_arb_checker.sv
// imem_arb_checker: protocol checks for the memory side of imem_arbiter.
// A burst is exactly BEATS cycles of mem_read, memory must have finished
// (busywait low) on the last beat, and at most one port owns the memory.
module imem_arb_checker #(
    parameter int BEATS = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       mem_read,
    input  logic       mem_busywait,
    input  logic [1:0] grant
);

    localparam int RUN_W = $clog2(BEATS) + 1;

    logic [RUN_W-1:0] run_r;

    // Length of the mem_read burst in progress
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            run_r <= '0;
        end else if (mem_read) begin
            run_r <= run_r + RUN_W'(1);
        end else begin
            run_r <= '0;
        end
    end

    // Burst length, last-beat completion and single-owner rules
    always @(posedge clock) begin
        if (reset) begin
            if (mem_read && (run_r == RUN_W'(BEATS - 1))) begin
                assert (!mem_busywait);
            end
            if (!mem_read && (run_r != '0)) begin
                assert (run_r == RUN_W'(BEATS));
            end
            assert ($onehot0(grant));
        end
    end

endmodule

// File: rtl/imem_arb_pick.sv
// imem_arb_pick: combinational owner selection for the instruction-memory arbiter.
// Configuration macro IMEM_ARB_RR_EN:
//   defined   - round-robin: on simultaneous requests the port that did not
//               own the last acknowledged burst wins.
//   undefined - fixed priority: the active i-cache (port 0) always wins and the
//               standby cache may starve while the active cache keeps asking.
module imem_arb_pick
    import imem_arb_pkg::*;
(
    input  logic [N_PORTS-1:0] req_read,
    input  logic               last_owner,
    output logic [N_PORTS-1:0] pick
);

`ifndef IMEM_ARB_RR_EN
    // last_owner only steers round-robin selection
    logic unused_last_owner_s;
    assign unused_last_owner_s = last_owner;
`endif

    // Choose the next owner (one-hot, zero when nobody is requesting)
    always_comb begin
        pick = 2'b00;
`ifdef IMEM_ARB_RR_EN
        if (req_read == 2'b11) begin
            if (last_owner == 1'b1) begin
                pick = 2'b01;
            end else begin
                pick = 2'b10;
            end
        end else if (req_read[PORT_ACTIVE]) begin
            pick = 2'b01;
        end else if (req_read[PORT_STANDBY]) begin
            pick = 2'b10;
        end else begin
            pick = 2'b00;
        end
`else
        if (req_read[PORT_ACTIVE]) begin
            pick = 2'b01;
        end else if (req_read[PORT_STANDBY]) begin
            pick = 2'b10;
        end else begin
            pick = 2'b00;
        end
`endif
    end

endmodule

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares the byte-serial instruction memory (BEATS beats per
// block) between the active i-cache (port 0) and the standby i-cache (port 1).
// A granted request runs a full BEATS-cycle burst at the latched block address,
// the block is captured one cycle after the burst and the owner is acknowledged
// (busywait dropped) for one cycle. A requester that withdraws mid-burst is not
// acknowledged; the burst still completes so the memory beat counter stays aligned.
// Configuration macro IMEM_ARB_RR_EN (see imem_arb_pick): round-robin when
// defined, fixed priority for port 0 otherwise.
module imem_arbiter
    import imem_arb_pkg::*;
#(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128,
    parameter int BEATS  = DEF_BEATS
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [N_PORTS-1:0]            req_read,
    input  logic [N_PORTS-1:0][ADDR_W-1:0] req_address,
    output logic [DATA_W-1:0]             req_readdata,
    output logic [N_PORTS-1:0]            req_busywait,
    output logic                          mem_read,
    output logic [ADDR_W-1:0]             mem_address,
    input  logic [DATA_W-1:0]             mem_readdata,
    input  logic                          mem_busywait,
    output logic [N_PORTS-1:0]            grant
);

    localparam int               BEAT_W    = $clog2(BEATS);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);

    arb_state_e          state_r;
    logic [BEAT_W-1:0]   beat_r;
    logic [N_PORTS-1:0]  ack_r;
    logic                last_owner_r;
    logic                dropped_r;
    logic [N_PORTS-1:0]  pick_s;
    logic                owner_dropped_s;

    // Completion is signalled by the memory only on the last beat; the fixed
    // beat count below is what actually ends the burst.
    logic unused_mem_busywait_s;
    assign unused_mem_busywait_s = mem_busywait;

    imem_arb_pick u_pick (
        .req_read   (req_read),
        .last_owner (last_owner_r),
        .pick       (pick_s)
    );

    // Owner has withdrawn its request during the current burst
    assign owner_dropped_s = |(grant & ~req_read);

    // A requester stalls until its one-cycle acknowledge
    assign req_busywait = req_read & ~ack_r;

    // Arbitration sequencer: grant, fixed-length burst, block capture, acknowledge
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            beat_r       <= '0;
            mem_read     <= 1'b0;
            mem_address  <= '0;
            req_readdata <= '0;
            grant        <= 2'b00;
            ack_r        <= 2'b00;
            last_owner_r <= 1'b1;
            dropped_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    ack_r <= 2'b00;
                    if (pick_s != 2'b00) begin
                        grant       <= pick_s;
                        mem_address <= req_address[grant_index(pick_s)];
                        beat_r      <= '0;
                        mem_read    <= 1'b1;
                        dropped_r   <= 1'b0;
                        state_r     <= ST_BUSY;
                    end else begin
                        grant    <= 2'b00;
                        mem_read <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    if (owner_dropped_s) begin
                        dropped_r <= 1'b1;
                    end
                    if (beat_r == BEAT_LAST) begin
                        // Memory counter wraps here; mem_read must fall now
                        mem_read <= 1'b0;
                        beat_r   <= '0;
                        state_r  <= ST_CAPTURE;
                    end else begin
                        beat_r <= beat_r + BEAT_W'(1);
                    end
                end
                ST_CAPTURE: begin
                    req_readdata <= mem_readdata;
                    if (dropped_r || owner_dropped_s) begin
                        // Withdrawn request: no acknowledge, release at once
                        grant   <= 2'b00;
                        state_r <= ST_IDLE;
                    end else begin
                        ack_r   <= grant;
                        state_r <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    ack_r        <= 2'b00;
                    last_owner_r <= grant_index(grant);
                    grant        <= 2'b00;
                    state_r      <= ST_IDLE;
                end
                default: begin
                    state_r  <= ST_IDLE;
                    beat_r   <= '0;
                    mem_read <= 1'b0;
                    grant    <= 2'b00;
                    ack_r    <= 2'b00;
                end
            endcase
        end
    end

endmodule
